axi_rd_arbiter: RTL and testbench

Two-master, one-slave AXI4 read-channel arbiter placed between the instruction-fetch unit (master 0) and the load/store unit (master 1) in front of the simulated SRAM slave. It grants the single AR/R path to one master at a time using round-robin priority. It holds the grant until the slave returns the last beat of the burst. It also checks burst length and reports mismatches. The write channels (AW/W/B) connect from the LSU to the slave outside this block.

---
 rtl/axi_rd_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_axi_rd_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master, one-slave AXI4 read-channel arbiter with round-robin grant,
// a grant held until the last R beat, and a sticky burst-length check.
module axi_rd_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 4
) (
  input  logic              aclk,
  input  logic              aresetn,
  // master 0 (instruction fetch)
  input  logic [ADDR_W-1:0] m0_araddr,
  input  logic [ID_W-1:0]   m0_arid,
  input  logic [7:0]        m0_arlen,
  input  logic [2:0]        m0_arsize,
  input  logic [1:0]        m0_arburst,
  input  logic              m0_arvalid,
  output logic              m0_arready,
  output logic [ID_W-1:0]   m0_rid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [1:0]        m0_rresp,
  output logic              m0_rlast,
  output logic              m0_rvalid,
  input  logic              m0_rready,
  // master 1 (load/store)
  input  logic [ADDR_W-1:0] m1_araddr,
  input  logic [ID_W-1:0]   m1_arid,
  input  logic [7:0]        m1_arlen,
  input  logic [2:0]        m1_arsize,
  input  logic [1:0]        m1_arburst,
  input  logic              m1_arvalid,
  output logic              m1_arready,
  output logic [ID_W-1:0]   m1_rid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [1:0]        m1_rresp,
  output logic              m1_rlast,
  output logic              m1_rvalid,
  input  logic              m1_rready,
  // slave
  output logic [ADDR_W-1:0] s_araddr,
  output logic [ID_W-1:0]   s_arid,
  output logic [7:0]        s_arlen,
  output logic [2:0]        s_arsize,
  output logic [1:0]        s_arburst,
  output logic              s_arvalid,
  input  logic              s_arready,
  input  logic [ID_W-1:0]   s_rid,
  input  logic [DATA_W-1:0] s_rdata,
  input  logic [1:0]        s_rresp,
  input  logic              s_rlast,
  input  logic              s_rvalid,
  output logic              s_rready,
  // status
  output logic              owner,
  output logic              busy,
  output logic              len_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t     state_reg, state_next;
  logic       owner_reg, owner_next;
  logic [7:0] len_q_reg, len_q_next;
  logic [7:0] beat_cnt_reg, beat_cnt_next;
  logic       len_err_reg, len_err_next;
  logic       busy_reg;
  logic       grant;
  logic       ar_hs;
  logic       rd_hs;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_reg    <= IDLE;
      owner_reg    <= 1'b1;
      len_q_reg    <= 8'd0;
      beat_cnt_reg <= 8'd0;
      len_err_reg  <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      owner_reg    <= owner_next;
      len_q_reg    <= len_q_next;
      beat_cnt_reg <= beat_cnt_next;
      len_err_reg  <= len_err_next;
      busy_reg     <= (state_next != IDLE);
    end
  end

  assign ar_hs = (state_reg == ADDR) && s_arvalid && s_arready;
  assign rd_hs = (state_reg == DATA) && s_rvalid && s_rready;

  // On a tie the master that did not hold the last grant wins.
  assign grant = (m0_arvalid && m1_arvalid) ? ~owner_reg : m1_arvalid;

  always_comb begin
    state_next    = state_reg;
    owner_next    = owner_reg;
    len_q_next    = len_q_reg;
    beat_cnt_next = beat_cnt_reg;
    len_err_next  = len_err_reg;
    case (state_reg)
      IDLE: begin
        if (m0_arvalid || m1_arvalid) begin
          owner_next    = grant;
          len_q_next    = grant ? m1_arlen : m0_arlen;
          beat_cnt_next = 8'd0;
          state_next    = ADDR;
        end
      end
      ADDR: begin
        if (ar_hs) state_next = DATA;
      end
      DATA: begin
        if (rd_hs) begin
          beat_cnt_next = beat_cnt_reg + 8'd1;
          if (s_rlast) begin
            state_next = IDLE;
            if (beat_cnt_reg != len_q_reg) len_err_next = 1'b1;
          end else if (beat_cnt_reg == len_q_reg) begin
            len_err_next = 1'b1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Routing is purely combinational from the registered state and owner.
  always_comb begin
    s_araddr   = '0;
    s_arid     = '0;
    s_arlen    = '0;
    s_arsize   = '0;
    s_arburst  = '0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m0_arready = 1'b0;
    m0_rid     = '0;
    m0_rdata   = '0;
    m0_rresp   = '0;
    m0_rlast   = 1'b0;
    m0_rvalid  = 1'b0;
    m1_arready = 1'b0;
    m1_rid     = '0;
    m1_rdata   = '0;
    m1_rresp   = '0;
    m1_rlast   = 1'b0;
    m1_rvalid  = 1'b0;
    if (state_reg == ADDR) begin
      if (owner_reg) begin
        s_araddr   = m1_araddr;
        s_arid     = m1_arid;
        s_arlen    = m1_arlen;
        s_arsize   = m1_arsize;
        s_arburst  = m1_arburst;
        s_arvalid  = m1_arvalid;
        m1_arready = s_arready;
      end else begin
        s_araddr   = m0_araddr;
        s_arid     = m0_arid;
        s_arlen    = m0_arlen;
        s_arsize   = m0_arsize;
        s_arburst  = m0_arburst;
        s_arvalid  = m0_arvalid;
        m0_arready = s_arready;
      end
    end
    if (state_reg == DATA) begin
      if (owner_reg) begin
        s_rready  = m1_rready;
        m1_rid    = s_rid;
        m1_rdata  = s_rdata;
        m1_rresp  = s_rresp;
        m1_rlast  = s_rlast;
        m1_rvalid = s_rvalid;
      end else begin
        s_rready  = m0_rready;
        m0_rid    = s_rid;
        m0_rdata  = s_rdata;
        m0_rresp  = s_rresp;
        m0_rlast  = s_rlast;
        m0_rvalid = s_rvalid;
      end
    end
  end

  assign owner   = owner_reg;
  assign busy    = busy_reg;
  assign len_err = len_err_reg;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: the bench plays both masters and the
// SRAM slave, and checks grants, routing, beat counts and the length flag.
module tb_axi_rd_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 64;
  localparam int ID_W   = 4;

  logic aclk = 1'b0;
  logic aresetn = 1'b0;
  always #5 aclk = ~aclk;

  logic [ADDR_W-1:0] m0_araddr, m1_araddr, s_araddr;
  logic [ID_W-1:0]   m0_arid, m1_arid, s_arid;
  logic [7:0]        m0_arlen, m1_arlen, s_arlen;
  logic [2:0]        m0_arsize, m1_arsize, s_arsize;
  logic [1:0]        m0_arburst, m1_arburst, s_arburst;
  logic              m0_arvalid, m1_arvalid, s_arvalid;
  logic              m0_arready, m1_arready, s_arready;
  logic [ID_W-1:0]   m0_rid, m1_rid, s_rid;
  logic [DATA_W-1:0] m0_rdata, m1_rdata, s_rdata;
  logic [1:0]        m0_rresp, m1_rresp, s_rresp;
  logic              m0_rlast, m1_rlast, s_rlast;
  logic              m0_rvalid, m1_rvalid, s_rvalid;
  logic              m0_rready, m1_rready, s_rready;
  logic              owner, busy, len_err;

  int n_checks = 0;
  int n_fail   = 0;
  int txn      = 0;

  axi_rd_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .m0_araddr(m0_araddr), .m0_arid(m0_arid), .m0_arlen(m0_arlen),
    .m0_arsize(m0_arsize), .m0_arburst(m0_arburst), .m0_arvalid(m0_arvalid),
    .m0_arready(m0_arready), .m0_rid(m0_rid), .m0_rdata(m0_rdata),
    .m0_rresp(m0_rresp), .m0_rlast(m0_rlast), .m0_rvalid(m0_rvalid),
    .m0_rready(m0_rready),
    .m1_araddr(m1_araddr), .m1_arid(m1_arid), .m1_arlen(m1_arlen),
    .m1_arsize(m1_arsize), .m1_arburst(m1_arburst), .m1_arvalid(m1_arvalid),
    .m1_arready(m1_arready), .m1_rid(m1_rid), .m1_rdata(m1_rdata),
    .m1_rresp(m1_rresp), .m1_rlast(m1_rlast), .m1_rvalid(m1_rvalid),
    .m1_rready(m1_rready),
    .s_araddr(s_araddr), .s_arid(s_arid), .s_arlen(s_arlen),
    .s_arsize(s_arsize), .s_arburst(s_arburst), .s_arvalid(s_arvalid),
    .s_arready(s_arready), .s_rid(s_rid), .s_rdata(s_rdata),
    .s_rresp(s_rresp), .s_rlast(s_rlast), .s_rvalid(s_rvalid),
    .s_rready(s_rready),
    .owner(owner), .busy(busy), .len_err(len_err)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    aresetn    = 1'b0;
    m0_arvalid = 1'b0;
    m1_arvalid = 1'b0;
    m0_rready  = 1'b0;
    m1_rready  = 1'b0;
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    s_rlast    = 1'b0;
    s_rdata    = '0;
    s_rid      = '0;
    s_rresp    = '0;
    repeat (2) @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  // Acts as the slave for one burst granted to exp_owner. The slave ends the
  // burst with rlast on beat index last_beat; abort_beat >= 0 asserts reset
  // while that beat is on the bus.
  task automatic serve(input int exp_owner, input int last_beat, input bit toggle,
                       input int abort_beat, output int beats);
    bit seen;
    bit rr;
    logic [63:0] exp_data;
    logic [ID_W-1:0] exp_id;
    logic [7:0] exp_len;
    logic [ADDR_W-1:0] exp_addr;
    exp_id   = exp_owner != 0 ? m1_arid : m0_arid;
    exp_len  = exp_owner != 0 ? m1_arlen : m0_arlen;
    exp_addr = exp_owner != 0 ? m1_araddr : m0_araddr;
    beats = 0;
    seen  = 1'b0;
    for (int cyc = 0; cyc < 20 && !seen; cyc++) begin
      @(negedge aclk);
      if (s_arvalid) seen = 1'b1;
    end
    check_val("ar_timeout", 64'(seen), 64'd1);
    if (!seen) return;
    check_val("owner", 64'(owner), 64'(exp_owner));
    check_val("s_araddr", 64'(s_araddr), 64'(exp_addr));
    check_val("s_arid", 64'(s_arid), 64'(exp_id));
    check_val("s_arlen", 64'(s_arlen), 64'(exp_len));
    s_arready = 1'b1;
    #1;
    check_val("own_arready", 64'(exp_owner != 0 ? m1_arready : m0_arready), 64'd1);
    check_val("oth_arready", 64'(exp_owner != 0 ? m0_arready : m1_arready), 64'd0);
    @(negedge aclk);
    s_arready = 1'b0;
    txn++;
    for (int cyc = 0; cyc < 64; cyc++) begin
      rr = toggle ? (cyc % 2 == 0) : 1'b1;
      if (exp_owner != 0) begin m1_rready = rr; m0_rready = 1'b1; end
      else begin m0_rready = rr; m1_rready = 1'b1; end
      exp_data = 64'hA5A5_0000_0000_0000 | (64'(txn) << 8) | 64'(beats);
      s_rvalid = 1'b1;
      s_rdata  = exp_data;
      s_rid    = exp_id;
      s_rresp  = 2'(beats);
      s_rlast  = (beats == last_beat);
      #1;
      check_val("s_rready", 64'(s_rready), 64'(rr));
      check_val("own_rvalid", 64'(exp_owner != 0 ? m1_rvalid : m0_rvalid), 64'd1);
      check_val("own_rdata", exp_owner != 0 ? m1_rdata : m0_rdata, exp_data);
      check_val("own_rid", 64'(exp_owner != 0 ? m1_rid : m0_rid), 64'(exp_id));
      check_val("own_rlast", 64'(exp_owner != 0 ? m1_rlast : m0_rlast), 64'(beats == last_beat));
      check_val("oth_rvalid", 64'(exp_owner != 0 ? m0_rvalid : m1_rvalid), 64'd0);
      check_val("oth_rdata", exp_owner != 0 ? m0_rdata : m1_rdata, 64'd0);
      check_val("oth_arready", 64'(exp_owner != 0 ? m0_arready : m1_arready), 64'd0);
      if (beats == abort_beat) begin
        aresetn = 1'b0;
        #1;
        check_val("rst_owner", 64'(owner), 64'd1);
        check_val("rst_busy", 64'(busy), 64'd0);
        check_val("rst_len_err", 64'(len_err), 64'd0);
        check_val("rst_s_rready", 64'(s_rready), 64'd0);
        check_val("rst_m1_rvalid", 64'(m1_rvalid), 64'd0);
        check_val("rst_m0_rvalid", 64'(m0_rvalid), 64'd0);
        check_val("rst_s_arvalid", 64'(s_arvalid), 64'd0);
        s_rvalid = 1'b0;
        s_rlast  = 1'b0;
        return;
      end
      @(negedge aclk);
      if (rr) begin
        beats++;
        if (s_rlast) break;
      end
    end
    s_rvalid  = 1'b0;
    s_rlast   = 1'b0;
    m0_rready = 1'b0;
    m1_rready = 1'b0;
  endtask

  initial begin
    int b;
    m0_araddr = 32'h8000_0000; m0_arid = 4'h3; m0_arlen = 8'd0;
    m0_arsize = 3'd3; m0_arburst = 2'b01;
    m1_araddr = 32'h4000_0100; m1_arid = 4'h9; m1_arlen = 8'd3;
    m1_arsize = 3'd3; m1_arburst = 2'b01;
    s_arready = 1'b0; s_rvalid = 1'b0; s_rlast = 1'b0;
    s_rdata = '0; s_rid = '0; s_rresp = '0;
    m0_arvalid = 1'b0; m1_arvalid = 1'b0; m0_rready = 1'b0; m1_rready = 1'b0;
    aresetn = 1'b0;
    repeat (2) @(negedge aclk);
    check_val("reset_owner", 64'(owner), 64'd1);
    check_val("reset_busy", 64'(busy), 64'd0);
    check_val("reset_len_err", 64'(len_err), 64'd0);
    check_val("reset_s_arvalid", 64'(s_arvalid), 64'd0);
    check_val("reset_s_rready", 64'(s_rready), 64'd0);
    check_val("reset_m0_arready", 64'(m0_arready), 64'd0);
    aresetn = 1'b1;
    @(negedge aclk);

    // single m0 read, arlen 0; s_arvalid one cycle after m0_arvalid
    m0_arvalid = 1'b1;
    #1;
    check_val("lat_cycle_n", 64'(s_arvalid), 64'd0);
    @(negedge aclk);
    check_val("lat_cycle_n1", 64'(s_arvalid), 64'd1);
    check_val("busy_granted", 64'(busy), 64'd1);
    serve(0, 0, 1'b0, -1, b);
    m0_arvalid = 1'b0;
    check_val("t1_beats", 64'(b), 64'd1);
    check_val("t1_busy", 64'(busy), 64'd0);
    check_val("t1_len_err", 64'(len_err), 64'd0);
    $display("txn single_m0: beats=%0d owner=%0d len_err=%0d", b, owner, len_err);

    // simultaneous requests straight out of reset
    do_reset();
    m0_arlen = 8'd1; m1_arlen = 8'd1;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    serve(0, 1, 1'b0, -1, b);
    check_val("t2_m0_beats", 64'(b), 64'd2);
    $display("txn tie_first: owner=%0d beats=%0d", owner, b);
    serve(1, 1, 1'b0, -1, b);
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;
    check_val("t2_m1_beats", 64'(b), 64'd2);
    $display("txn tie_second: owner=%0d beats=%0d", owner, b);

    // round-robin over six back-to-back 4-beat bursts
    m0_arlen = 8'd3; m1_arlen = 8'd3;
    m0_arvalid = 1'b1; m1_arvalid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      serve(i % 2, 3, 1'b0, -1, b);
      check_val("rr_beats", 64'(b), 64'd4);
      check_val("rr_turn_busy", 64'(busy), 64'd0);
      check_val("rr_turn_arvalid", 64'(s_arvalid), 64'd0);
      $display("txn rr[%0d]: owner=%0d beats=%0d", i, owner, b);
    end
    m0_arvalid = 1'b0; m1_arvalid = 1'b0;

    // early rlast: arlen 3 but slave ends after 3 beats
    m1_arvalid = 1'b1;
    serve(1, 2, 1'b0, -1, b);
    m1_arvalid = 1'b0;
    check_val("t4_beats", 64'(b), 64'd3);
    check_val("t4_len_err", 64'(len_err), 64'd1);
    check_val("t4_busy", 64'(busy), 64'd0);
    $display("txn short_burst: beats=%0d len_err=%0d", b, len_err);
    m0_arlen = 8'd0;
    m0_arvalid = 1'b1;
    serve(0, 0, 1'b0, -1, b);
    m0_arvalid = 1'b0;
    check_val("t4_sticky", 64'(len_err), 64'd1);
    $display("txn sticky_check: beats=%0d len_err=%0d", b, len_err);

    // backpressure: owner rready toggles every cycle
    m0_arlen = 8'd3;
    m0_arvalid = 1'b1;
    serve(0, 3, 1'b1, -1, b);
    m0_arvalid = 1'b0;
    check_val("t5_beats", 64'(b), 64'd4);
    $display("txn backpressure: beats=%0d", b);

    // reset during beat 2 of a 4-beat m1 burst
    m1_arvalid = 1'b1;
    serve(1, 3, 1'b0, 2, b);
    m1_arvalid = 1'b0;
    m0_rready = 1'b0; m1_rready = 1'b0;
    check_val("t6_beats_before", 64'(b), 64'd2);
    @(negedge aclk);
    aresetn = 1'b1;
    @(negedge aclk);
    check_val("t6_post_busy", 64'(busy), 64'd0);
    check_val("t6_post_owner", 64'(owner), 64'd1);
    $display("txn reset_mid_burst: beats_before=%0d owner=%0d", b, owner);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
